// File: rtl/serial_port_fifo.sv
// Buffered 8N1 UART: 16x oversampled receiver and a transmitter, each behind
// its own circular FIFO, with sticky RX error flags and a level interrupt.
module serial_port_fifo #(
  parameter int CLK_FREQ      = 0,
  parameter int BAUD          = 115200,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rx_empty,
  output logic [RX_DEPTH_LOG2:0]   rx_count,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     tx_full,
  output logic [TX_DEPTH_LOG2:0]   tx_count,
  output logic                     tx_idle,
  input  logic                     irq_rx_en,
  input  logic                     irq_tx_en,
  output logic                     int_req,
  output logic                     rx_overrun,
  output logic                     rx_frame_err,
  input  logic                     clr_err,
  output logic                     TxD,
  input  logic                     RxD
);

  localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RA  = RX_DEPTH_LOG2;
  localparam int TA  = TX_DEPTH_LOG2;

  if (DIV < 1) begin : g_bad_div
    $error("serial_port_fifo: CLK_FREQ/(16*BAUD) rounds below 1");
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [CW-1:0] div_q, div_d;
  logic          tick;
  logic          rx_s1_q, rx_s2_q;

  rx_state_t     rx_st_q, rx_st_d;
  logic [3:0]    rx_tc_q, rx_tc_d;
  logic [2:0]    rx_bc_q, rx_bc_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_byte_vld, rx_ferr_evt;

  tx_state_t     tx_st_q, tx_st_d;
  logic [3:0]    tx_tc_q, tx_tc_d;
  logic [2:0]    tx_bc_q, tx_bc_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;
  logic          tx_pop;

  logic [RA:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [7:0]    rx_mem [2**RA];
  logic          rx_full, rx_pop, rx_push, rx_ovr_evt;

  logic [TA:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [7:0]    tx_mem [2**TA];
  logic          tx_empty, tx_push;
  logic [7:0]    tx_head;

  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          tx_idle_q, tx_idle_d;
  logic          int_q, int_d;

  assign tick = (div_q == CW'(DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Receiver: every decision is taken on a baud tick using the synchronised line
  always_comb begin
    rx_st_d     = rx_st_q;
    rx_tc_d     = rx_tc_q;
    rx_bc_d     = rx_bc_q;
    rx_sh_d     = rx_sh_q;
    rx_byte_vld = 1'b0;
    rx_ferr_evt = 1'b0;
    if (tick) begin
      case (rx_st_q)
        RX_IDLE: if (!rx_s2_q) begin
          rx_st_d = RX_START;
          rx_tc_d = '0;
        end
        RX_START: if (rx_tc_q == 4'd7) begin
          rx_tc_d = '0;
          rx_bc_d = '0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_tc_d = rx_tc_q + 1'b1;
        RX_DATA: if (rx_tc_q == 4'd15) begin
          rx_tc_d = '0;
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          rx_bc_d = rx_bc_q + 1'b1;
          if (rx_bc_q == 3'd7) rx_st_d = RX_STOP;
        end else rx_tc_d = rx_tc_q + 1'b1;
        RX_STOP: if (rx_tc_q == 4'd15) begin
          rx_tc_d = '0;
          if (rx_s2_q) begin
            rx_byte_vld = 1'b1;
            rx_st_d     = RX_IDLE;
          end else begin
            rx_ferr_evt = 1'b1;
            rx_st_d     = RX_WAIT;
          end
        end else rx_tc_d = rx_tc_q + 1'b1;
        RX_WAIT: if (rx_s2_q) rx_st_d = RX_IDLE;
        default: rx_st_d = RX_IDLE;
      endcase
    end
  end

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RA] != rx_rp_q[RA]) && (rx_wp_q[RA-1:0] == rx_rp_q[RA-1:0]);
  assign rx_count = rx_wp_q - rx_rp_q;
  assign rd_data  = rx_empty ? 8'h00 : rx_mem[rx_rp_q[RA-1:0]];

  // A pop in the same cycle frees the slot, so a byte arriving when full still lands
  always_comb begin
    rx_pop     = rd_en & ~rx_empty;
    rx_push    = rx_byte_vld & (~rx_full | rx_pop);
    rx_ovr_evt = rx_byte_vld & rx_full & ~rx_pop;
    rx_wp_d    = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d    = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
  end

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TA] != tx_rp_q[TA]) && (tx_wp_q[TA-1:0] == tx_rp_q[TA-1:0]);
  assign tx_count = tx_wp_q - tx_rp_q;
  assign tx_head  = tx_mem[tx_rp_q[TA-1:0]];

  // Transmitter: the stop bit reloads directly so queued frames run back-to-back
  always_comb begin
    tx_st_d = tx_st_q;
    tx_tc_d = tx_tc_q;
    tx_bc_d = tx_bc_q;
    tx_sh_d = tx_sh_q;
    tx_pop  = 1'b0;
    if (tick) begin
      case (tx_st_q)
        TX_IDLE: if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_sh_d = tx_head;
          tx_tc_d = '0;
          tx_st_d = TX_START;
        end
        TX_START: if (tx_tc_q == 4'd15) begin
          tx_tc_d = '0;
          tx_bc_d = '0;
          tx_st_d = TX_DATA;
        end else tx_tc_d = tx_tc_q + 1'b1;
        TX_DATA: if (tx_tc_q == 4'd15) begin
          tx_tc_d = '0;
          tx_sh_d = {1'b0, tx_sh_q[7:1]};
          tx_bc_d = tx_bc_q + 1'b1;
          if (tx_bc_q == 3'd7) tx_st_d = TX_STOP;
        end else tx_tc_d = tx_tc_q + 1'b1;
        TX_STOP: if (tx_tc_q == 4'd15) begin
          tx_tc_d = '0;
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_sh_d = tx_head;
            tx_st_d = TX_START;
          end else tx_st_d = TX_IDLE;
        end else tx_tc_d = tx_tc_q + 1'b1;
        default: tx_st_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_push = wr_en & (~tx_full | tx_pop);
    tx_wp_d = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
    txd_d   = (tx_st_d == TX_START) ? 1'b0 :
              (tx_st_d == TX_DATA)  ? tx_sh_d[0] : 1'b1;
    tx_idle_d = (tx_st_d == TX_IDLE) && (tx_wp_d == tx_rp_d);
    ovr_d   = (ovr_q  & ~clr_err) | rx_ovr_evt;
    ferr_d  = (ferr_q & ~clr_err) | rx_ferr_evt;
    int_d   = (irq_rx_en & (rx_wp_d != rx_rp_d)) | (irq_tx_en & tx_idle_d) | ovr_d | ferr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_tc_q   <= '0;
      rx_bc_q   <= '0;
      tx_st_q   <= TX_IDLE;
      tx_tc_q   <= '0;
      tx_bc_q   <= '0;
      txd_q     <= 1'b1;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      tx_idle_q <= 1'b1;
      int_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      rx_s1_q   <= RxD;
      rx_s2_q   <= rx_s1_q;
      rx_st_q   <= rx_st_d;
      rx_tc_q   <= rx_tc_d;
      rx_bc_q   <= rx_bc_d;
      tx_st_q   <= tx_st_d;
      tx_tc_q   <= tx_tc_d;
      tx_bc_q   <= tx_bc_d;
      txd_q     <= txd_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      tx_idle_q <= tx_idle_d;
      int_q     <= int_d;
    end
  end

  // Data-only storage; validity is tracked by the pointers and FSM states
  always_ff @(posedge clk) begin
    rx_sh_q <= rx_sh_d;
    tx_sh_q <= tx_sh_d;
    if (rx_push) rx_mem[rx_wp_q[RA-1:0]] <= rx_sh_q;
    if (tx_push) tx_mem[tx_wp_q[TA-1:0]] <= wr_data;
  end

  assign TxD          = txd_q;
  assign tx_idle      = tx_idle_q;
  assign int_req      = int_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_serial_port_fifo.sv
// Scoreboard bench for serial_port_fifo at DIV=1 (16 clocks per bit):
// queued expected bytes are checked by line/read monitors.
module tb_serial_port_fifo;
  localparam int CLK_FREQ = 1843200;
  localparam int BAUD     = 115200;
  localparam int RXL      = 2;
  localparam int TXL      = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rd_en = 1'b0, wr_en = 1'b0, clr_err = 1'b0;
  logic           irq_rx_en = 1'b0, irq_tx_en = 1'b0, RxD = 1'b1;
  logic [7:0]     wr_data = 8'h00;
  logic [7:0]     rd_data;
  logic           rx_empty, tx_full, tx_idle, int_req, rx_overrun, rx_frame_err, TxD;
  logic [RXL:0]   rx_count;
  logic [TXL:0]   tx_count;

  serial_port_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD),
                     .RX_DEPTH_LOG2(RXL), .TX_DEPTH_LOG2(TXL)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_count(rx_count), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_count(tx_count), .tx_idle(tx_idle), .irq_rx_en(irq_rx_en), .irq_tx_en(irq_tx_en),
    .int_req(int_req), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .clr_err(clr_err), .TxD(TxD), .RxD(RxD));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int tx_starts[$];
  int rxm_cnt = 0;
  int txm_cnt = 0;
  logic exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model for the receive side: 4-byte buffer, overflow is remembered
  task automatic rx_model_push(input logic [7:0] b);
    if (rxm_cnt < (1 << RXL)) begin
      exp_rx.push_back(b);
      rxm_cnt++;
    end else exp_ovr = 1'b1;
  endtask

  task automatic tx_write(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    if (txm_cnt < (1 << TXL)) begin
      exp_tx.push_back(b);
      txm_cnt++;
    end
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RxD = f[i];
      step(16);
    end
    RxD = 1'b1;
    step(4);
  endtask

  task automatic wait_tx_drained(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (tx_idle && exp_tx.size() == 0) break;
      step(1);
    end
    if (k >= limit) chk("tx_drain_timeout", k, limit - 1);
    txm_cnt = 0;
  endtask

  // Line monitor: decodes each TxD frame and checks it against the queue head
  initial begin
    logic [7:0] e, got;
    logic [9:0] fr;
    int bad;
    bit abort;
    forever begin
      @(negedge clk);
      if (!rst && TxD === 1'b0) begin
        tx_starts.push_back(cyc);
        if (exp_tx.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL tx_frame: frame started at cycle %0d with nothing queued", cyc);
          e = 8'h00;
        end else e = exp_tx.pop_front();
        fr = {1'b1, e, 1'b0};
        bad = 0;
        got = 8'h00;
        abort = 1'b0;
        for (int c = 0; c < 160; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (TxD !== fr[c/16]) bad++;
          if (c % 16 == 8 && c >= 16 && c < 144) got[c/16-1] = TxD;
        end
        if (!abort) begin
          chk("tx_byte", got, e);
          chk("tx_bit_timing_errors", bad, 0);
        end
      end
    end
  end

  // Read monitor: every accepted pop must present the next expected byte
  always @(negedge clk) begin
    if (!rst && rd_en && !rx_empty) begin
      if (exp_rx.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rx_data: popped %0h with nothing expected", rd_data);
      end else chk("rx_data", rd_data, exp_rx.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [7:0] b;
    logic [7:0] rx_pat [3];
    rx_pat[0] = 8'h3C; rx_pat[1] = 8'hFF; rx_pat[2] = 8'h00;

    step(3);
    chk("rst_TxD", TxD, 1);
    chk("rst_tx_idle", tx_idle, 1);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_rx_frame_err", rx_frame_err, 0);
    chk("rst_int_req", int_req, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step(3);

    // Single transmit of 0xA5: latency and drain timing
    tx_write(8'hA5);
    for (k = 0; k < 20; k++) begin
      if (TxD == 1'b0) break;
      step(1);
    end
    chk("tx_start_latency_ok", (k <= 2), 1);
    step(159);
    chk("tx_idle_before_160", tx_idle, 0);
    step(1);
    chk("tx_idle_at_160", tx_idle, 1);
    chk("tx_line_high_after", TxD, 1);
    txm_cnt = 0;

    // Receive three directed bytes, then drain them
    for (int i = 0; i < 3; i++) begin
      send_frame(rx_pat[i], 1'b1);
      rx_model_push(rx_pat[i]);
    end
    step(4);
    chk("rx_count_3", rx_count, rxm_cnt);
    chk("rx_not_empty", rx_empty, 0);
    rd_en = 1'b1;
    step(3);
    rd_en = 1'b0;
    rxm_cnt = 0;
    step(1);
    chk("rx_empty_after_read", rx_empty, 1);
    chk("rx_count_after_read", rx_count, 0);

    // Five random bytes into a four-deep FIFO
    exp_ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      rx_model_push(b);
    end
    step(4);
    chk("rx_count_full", rx_count, rxm_cnt);
    chk("rx_overrun_set", rx_overrun, exp_ovr);
    chk("int_on_overrun", int_req, 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    step(1);
    chk("rx_overrun_cleared", rx_overrun, 0);
    chk("int_after_clear", int_req, 0);
    irq_rx_en = 1'b1;
    step(2);
    chk("int_rx_enable", int_req, 1);
    rd_en = 1'b1;
    step(4);
    rd_en = 1'b0;
    rxm_cnt = 0;
    step(2);
    chk("rx_empty_after_drain", rx_empty, 1);
    chk("int_rx_empty", int_req, 0);
    irq_rx_en = 1'b0;

    // Bad stop bit, then a short glitch
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    step(10);
    chk("ferr_no_push", rx_count, 0);
    chk("ferr_set", rx_frame_err, 1);
    chk("int_on_ferr", int_req, 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    step(2);
    chk("ferr_cleared", rx_frame_err, 0);
    RxD = 1'b0;
    step(4);
    RxD = 1'b1;
    step(40);
    chk("glitch_no_byte", rx_count, 0);
    chk("glitch_no_ferr", rx_frame_err, 0);
    chk("glitch_no_ovr", rx_overrun, 0);
    irq_tx_en = 1'b1;
    step(2);
    chk("int_tx_idle", int_req, 1);
    irq_tx_en = 1'b0;
    step(2);

    // Burst: one byte into the shifter, sixteen to fill, one dropped
    tx_starts.delete();
    tx_write(8'($urandom_range(0, 255)));
    for (k = 0; k < 10; k++) begin
      if (tx_count == 0 && !tx_idle) break;
      step(1);
    end
    chk("tx_shifter_loaded", (k < 10), 1);
    txm_cnt = 0;
    for (int i = 0; i < 17; i++) tx_write(8'($urandom_range(0, 255)));
    chk("tx_count_full", tx_count, txm_cnt);
    chk("tx_full_set", tx_full, 1);
    wait_tx_drained(17 * 160 + 300);
    chk("tx_burst_frames", tx_starts.size(), 17);
    for (int i = 1; i < tx_starts.size(); i++)
      chk("tx_back_to_back_gap", tx_starts[i] - tx_starts[i-1], 160);

    // Reset in the middle of a frame
    tx_write(8'($urandom_range(0, 255)));
    tx_write(8'($urandom_range(0, 255)));
    step(50);
    rst = 1'b1;
    #1;
    chk("midrst_TxD", TxD, 1);
    chk("midrst_tx_count", tx_count, 0);
    chk("midrst_tx_idle", tx_idle, 1);
    exp_tx.delete();
    exp_rx.delete();
    txm_cnt = 0;
    rxm_cnt = 0;
    step(2);
    rst = 1'b0;
    step(2);
    tx_write(8'h55);
    wait_tx_drained(400);

    step(5);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rx_queue_empty", exp_rx.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_port_fifo.md
# serial_port_fifo

Buffered, parametrised UART for the CPU's memory-mapped serial device: 8N1 framing at a build-time baud rate, with independent RX and TX FIFOs of configurable depth. It replaces the single-byte, interrupt-per-character serial port. The CPU can queue bursts of output and drain received bytes in batches, with sticky overrun and framing-error reporting. It sits between the bus-side device register decoder and the physical TxD/RxD pins.

## Interface
- CLK_FREQ, 0: `clk` frequency in Hz; must be set by the instantiator.
- BAUD, 115200: line rate in bit/s.
- RX_DEPTH_LOG2, 4: RX FIFO holds 2^RX_DEPTH_LOG2 bytes.
- TX_DEPTH_LOG2, 4: TX FIFO holds 2^TX_DEPTH_LOG2 bytes.
- DIV is derived as CLK_FREQ/(16*BAUD), rounded to nearest; an elaboration error is raised if DIV < 1.

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rd_en  in  1  pop one byte from the RX FIFO; ignored when rx_empty.
- rd_data  out  8  RX FIFO head (show-ahead); valid while !rx_empty.
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  RX_DEPTH_LOG2+1  bytes held in the RX FIFO.
- wr_en  in  1  push wr_data into the TX FIFO; dropped when tx_full.
- wr_data  in  8  byte to transmit.
- tx_full  out  1  TX FIFO full.
- tx_count  out  TX_DEPTH_LOG2+1  bytes queued in the TX FIFO, excluding the byte in the shifter.
- tx_idle  out  1  TX FIFO empty and shifter idle; the line is fully drained.
- irq_rx_en, irq_tx_en  in  1  interrupt source enables.
- int_req  out  1  level interrupt.
- rx_overrun  out  1  sticky: a received byte was lost because the RX FIFO was full.
- rx_frame_err  out  1  sticky: a stop bit was sampled low.
- clr_err  in  1  clears both sticky flags.
- TxD  out  1  serial output; idle high.
- RxD  in  1  serial input; asynchronous to clk.

## Operation
- **Tick generator:** counter 0..DIV-1. It emits a one-cycle `tick` at DIV-1 and then wraps, so there are 16 ticks per bit.
- **RxD synchroniser:** 2-flop, reset to 1. All RX logic uses the synchronised value.
- **RX FSM (`tick` only):**
  - RX_IDLE: synced RxD = 0 → RX_START, sample count = 0.
  - RX_START: at the 8th tick (mid-start-bit), RxD = 0 → RX_DATA; RxD = 1 → RX_IDLE (glitch rejected).
  - RX_DATA: sample every 16 ticks. Bits shift in LSB first. After 8 bits → RX_STOP.
  - RX_STOP: sample after 16 ticks.
    - RxD = 1: byte is pushed. If the FIFO is full and no rd_en in the same cycle, the byte is discarded and rx_overrun is set.
    - RxD = 0: byte is discarded and rx_frame_err is set. The FSM waits for RxD = 1 before RX_IDLE.
  - Otherwise → RX_IDLE.
- **TX FSM:**
  - TX_IDLE: if the FIFO is non-empty on a tick, pop into the shifter and go to TX_START.
  - TX_START: TxD = 0 for 16 ticks.
  - TX_DATA: 8 bits, LSB first, 16 ticks each.
  - TX_STOP: TxD = 1 for 16 ticks. Then pop the next byte directly if the FIFO is non-empty (back-to-back frames, no idle gap); else → TX_IDLE.
- **FIFOs:** circular, with read/write pointers one bit wider than the address.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Simultaneous push and pop on a full or empty FIFO: the count is unchanged and both operations take effect. This does not apply to a pop on an empty FIFO.
- **Interrupt:** int_req = (irq_rx_en & !rx_empty) | (irq_tx_en & tx_idle) | rx_overrun | rx_frame_err.
- **Sticky flags:** clr_err in the same cycle as a new error event leaves the flag set (set wins).

## Timing
- **Reset values:**
  - TxD = 1; tx_idle = 1; rx_empty = 1.
  - rx_count = 0; tx_count = 0; tx_full = 0.
  - rx_overrun = 0; rx_frame_err = 0; int_req = 0; rd_data = 0.
  - Both FSMs in IDLE.
  - Tick counter = 0; synchroniser = 1.
- **Reset mid-frame:** the in-flight frame is aborted, TxD returns to 1 asynchronously, and all FIFO contents are discarded.
- **FIFO interface:**
  - wr_en at edge N → tx_count and tx_full update at N+1.
  - rd_en at edge N → rd_data, rx_count and rx_empty update at N+1.
- **TX start latency:** TxD falls at most DIV+1 cycles after the first write into an idle block.
- **Frame length:** exactly 160*DIV cycles.
- **RX latency:** the byte appears (rx_empty falls) 2–3 cycles of synchroniser/register delay plus at most DIV cycles after the nominal stop-bit midpoint.
- **Registered outputs:** int_req and all status outputs are registered, with no combinational path from input ports.

## Test plan
- CLK_FREQ=1843200, BAUD=115200 (DIV=1): write 0xA5 → TxD low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, high 16 cycles; tx_idle rises after 160 cycles.
- Drive frames 0x3C, 0xFF, 0x00 on RxD at 16 cycles/bit → rx_count = 3; reading with rd_en returns 0x3C, 0xFF, 0x00 in order, then rx_empty = 1.
- RX_DEPTH_LOG2=2, send 5 bytes without reading → rx_count = 4, rx_overrun = 1, the FIFO holds the first 4 bytes; pulse clr_err → rx_overrun = 0.
- Send a frame with stop bit 0 → no push, rx_frame_err = 1, int_req = 1 with both enables low. Send a 4-cycle low glitch → no byte, no error.
- Fill the TX FIFO (16 writes) plus 1 extra → tx_full = 1 and the extra byte is dropped. 16 frames are transmitted back-to-back with no idle gap.
- Assert rst mid-TX-frame → TxD = 1 immediately and tx_count = 0. After release, write 0x55 → a clean frame is sent.
